// File: rtl/pps_stream_if.sv
// pps_stream_if: handshake bundle for the streaming prefix-sum sequencer.
//   input side : in_valid / in_ready / in_data[N][IW] / in_last, plus clear
//   output side: out_valid / out_ready / out_psum[N][OW] / out_total / out_last / out_beat
// The master modport is the producer/consumer environment, the slave modport is pps_stream.
interface pps_stream_if #(
  parameter int NW = 5,
  parameter int IW = 4,
  parameter int OW = 6,
  parameter int BW = 8
);
  localparam int N = 1 << NW;

  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0][IW-1:0]   in_data;
  logic                   in_last;
  logic                   clear;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0][OW-1:0]   out_psum;
  logic [OW-1:0]          out_total;
  logic                   out_last;
  logic [BW-1:0]          out_beat;

  modport master (
    output in_valid, in_data, in_last, clear, out_ready,
    input  in_ready, out_valid, out_psum, out_total, out_last, out_beat
  );

  modport slave (
    input  in_valid, in_data, in_last, clear, out_ready,
    output in_ready, out_valid, out_psum, out_total, out_last, out_beat
  );
endinterface

// File: rtl/pps_stream.sv
// pps_stream: two-stage valid/ready wrapper around a parallel prefix sum.
// A beat is registered in stage 1, its lane-wise inclusive prefix sum is formed
// combinationally, and stage 2 registers that sum plus a running segment carry so
// prefix sums continue across the beats of a segment (all arithmetic mod 2^OW).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pps_stream_if.slave (input beat, clear, output beat handshakes)
module pps_stream #(
  parameter int NW = 5,
  parameter int IW = 4,
  parameter int OW = 6,
  parameter int BW = 8
) (
  input  logic           clk,
  input  logic           rst,
  pps_stream_if.slave    bus
);
  localparam int N = 1 << NW;

  typedef logic [N-1:0][IW-1:0] lanes_in_t;
  typedef logic [N-1:0][OW-1:0] lanes_out_t;

  // Wrapping unsigned add; overflow is silently discarded.
  function automatic logic [OW-1:0] add_wrap(input logic [OW-1:0] a, input logic [OW-1:0] b);
    return a + b;
  endfunction

  // Hillis-Steele inclusive scan. Walking k downward lets each level update in
  // place, because lane k only reads lower lanes not yet touched this level.
  function automatic lanes_out_t prefix_sum(input lanes_in_t d);
    lanes_out_t acc;
    for (int k = 0; k < N; k++) acc[k] = OW'(d[k]);
    for (int s = 0; s < NW; s++) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (k >= (1 << s)) acc[k] = add_wrap(acc[k], acc[k - (1 << s)]);
      end
    end
    return acc;
  endfunction

  logic          vld_p1, last_p1;
  lanes_in_t     data_p1;
  lanes_out_t    pps_p1;
  logic          vld_p2, last_p2;
  lanes_out_t    psum_p2;
  logic [OW-1:0] total_p2;
  logic [BW-1:0] beat_p2;
  logic [OW-1:0] carry, carry_used;
  logic [BW-1:0] beat, beat_used;
  logic          s1_load, s2_load, in_ready;

  always_comb begin
    s2_load    = vld_p1 && (!vld_p2 || bus.out_ready);
    in_ready   = !vld_p1 || s2_load;
    s1_load    = bus.in_valid && in_ready;
    carry_used = bus.clear ? '0 : carry;
    beat_used  = bus.clear ? '0 : beat;
    pps_p1     = prefix_sum(data_p1);
  end

  // ---- stage 1: input register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      data_p1 <= bus.in_data;
      last_p1 <= bus.in_last;
    end
  end

  // ---- stage 2: carried prefix sum, output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      psum_p2  <= '0;
      total_p2 <= '0;
      last_p2  <= 1'b0;
      beat_p2  <= '0;
    end else if (s2_load) begin
      vld_p2 <= 1'b1;
      for (int k = 0; k < N; k++) psum_p2[k] <= add_wrap(pps_p1[k], carry_used);
      total_p2 <= add_wrap(pps_p1[N-1], carry_used);
      last_p2  <= last_p1;
      beat_p2  <= beat_used;
    end else if (bus.out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  // Segment carry and beat index advance only when a beat enters stage 2, so a
  // clear affects the next beat loaded, never data already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= '0;
      beat  <= '0;
    end else if (s2_load) begin
      carry <= last_p1 ? '0 : add_wrap(carry_used, pps_p1[N-1]);
      beat  <= last_p1 ? '0 : beat_used + 1'b1;
    end else if (bus.clear) begin
      carry <= '0;
      beat  <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2;
  assign bus.out_psum  = psum_p2;
  assign bus.out_total = total_p2;
  assign bus.out_last  = last_p2;
  assign bus.out_beat  = beat_p2;
endmodule

// File: tb/tb_pps_stream.sv
// Testbench for pps_stream: directed scenarios from the test plan plus a randomized
// stream checked against a lane-by-lane running-sum model.
module tb_pps_stream;
  localparam int NW = 5, IW = 4, OW = 6, BW = 8;
  localparam int N = 1 << NW;
  localparam int OMASK = (1 << OW) - 1;

  typedef logic [N-1:0][IW-1:0] lanes_in_t;
  typedef logic [N-1:0][OW-1:0] lanes_out_t;
  typedef struct {
    lanes_out_t    psum;
    logic [OW-1:0] total;
    logic          last;
    logic [BW-1:0] beat;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    m_carry = 0;
  int    m_beat = 0;

  pps_stream_if #(.NW(NW), .IW(IW), .OW(OW), .BW(BW)) bus ();

  pps_stream #(.NW(NW), .IW(IW), .OW(OW), .BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted beat is a run of N additions continuing from
  // the segment's running total; observed output handshakes are recorded.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_carry = 0;
      m_beat = 0;
    end else begin
      if (bus.clear) begin
        m_carry = 0;
        m_beat = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        beat_t e;
        int run;
        run = m_carry;
        for (int k = 0; k < N; k++) begin
          run = (run + int'(bus.in_data[k])) & OMASK;
          e.psum[k] = OW'(run);
        end
        e.total = OW'(run);
        e.last = bus.in_last;
        e.beat = BW'(m_beat);
        exp_q.push_back(e);
        if (bus.in_last) begin
          m_carry = 0;
          m_beat = 0;
        end else begin
          m_carry = run;
          m_beat = (m_beat + 1) % (1 << BW);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_t g;
        g.psum = bus.out_psum;
        g.total = bus.out_total;
        g.last = bus.out_last;
        g.beat = bus.out_beat;
        got_q.push_back(g);
      end
    end
  end

  function automatic lanes_in_t fill(input int v);
    lanes_in_t d;
    for (int k = 0; k < N; k++) d[k] = IW'(v);
    return d;
  endfunction

  function automatic lanes_in_t rand_lanes();
    lanes_in_t d;
    for (int k = 0; k < N; k++) d[k] = IW'($urandom_range(0, (1 << IW) - 1));
    return d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input lanes_in_t d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 100 cycles", bus.in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready); end
    checks++;
    if (bus.out_psum !== '0 || bus.out_total !== '0 || bus.out_beat !== '0 || bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: psum=%h total=%0d beat=%0d last=%0b required all 0",
               bus.out_psum, bus.out_total, bus.out_beat, bus.out_last);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %0b required 1", bus.in_ready); end
  endtask

  task automatic test_single_ones();
    int bad;
    bus.in_valid = 1'b1;
    bus.in_data = fill(1);
    bus.in_last = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: out_valid=%0b required 0 one edge after accept", bus.out_valid); end
    tick(1);
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL latency: out_valid=%0b required 1 two edges after accept", bus.out_valid); end
    bad = 0;
    for (int k = 0; k < N; k++) if (int'(bus.out_psum[k]) != k + 1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL ones_psum: got %h, required lane k = k+1 (%0d lanes wrong)", bus.out_psum, bad); end
    checks++;
    if (bus.out_total !== 6'd32 || bus.out_beat !== 8'd0 || bus.out_last !== 1'b1) begin
      failures++;
      $display("FAIL ones_meta: total=%0d beat=%0d last=%0b required 32 0 1", bus.out_total, bus.out_beat, bus.out_last);
    end
    tick(2);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_order(input string name);
    int bad;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d beats required %0d", name, got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].psum !== exp_q[i].psum || got_q[i].total !== exp_q[i].total ||
          got_q[i].last !== exp_q[i].last || got_q[i].beat !== exp_q[i].beat) begin
        if (bad == 0)
          $display("FAIL %s_beat%0d: got psum=%h total=%0d last=%0b beat=%0d required psum=%h total=%0d last=%0b beat=%0d",
                   name, i, got_q[i].psum, got_q[i].total, got_q[i].last, got_q[i].beat,
                   exp_q[i].psum, exp_q[i].total, exp_q[i].last, exp_q[i].beat);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int bad;
    send_beat(fill(1), 1'b0);
    send_beat(fill(1), 1'b1);
    send_beat(fill(1), 1'b0);
    tick(4);
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL b2b_count: got %0d beats required 3", got_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < N; k++) if (int'(got_q[1].psum[k]) != (33 + k) % 64) bad++;
      checks++;
      if (bad != 0 || got_q[1].psum[N-1] !== 6'd0 || got_q[1].beat !== 8'd1) begin
        failures++;
        $display("FAIL b2b_second: psum=%h beat=%0d required lane k=(33+k)%%64, beat 1", got_q[1].psum, got_q[1].beat);
      end
      checks++;
      if (got_q[2].psum[0] !== 6'd1 || got_q[2].beat !== 8'd0) begin
        failures++;
        $display("FAIL b2b_third: psum0=%0d beat=%0d required 1 0", got_q[2].psum[0], got_q[2].beat);
      end
    end
    test_order("b2b");
  endtask

  task automatic test_clear();
    pulse_clear();
    send_beat(fill(2), 1'b0);
    tick(3);
    pulse_clear();
    send_beat(fill(2), 1'b0);
    tick(3);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL clear_count: got %0d beats required 2", got_q.size());
    end else if (got_q[1].psum[0] !== 6'd2 || got_q[1].beat !== 8'd0) begin
      failures++;
      $display("FAIL clear_beat2: psum0=%0d beat=%0d required 2 0", got_q[1].psum[0], got_q[1].beat);
    end
    test_order("clear");
  endtask

  task automatic test_fifteen();
    int bad;
    pulse_clear();
    send_beat(fill(15), 1'b1);
    tick(2);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL fifteen_count: got %0d beats required 1", got_q.size());
    end else begin
      bad = 0;
      for (int k = 0; k < N; k++) if (int'(got_q[0].psum[k]) != (15 * (k + 1)) % 64) bad++;
      checks++;
      if (bad != 0 || got_q[0].psum[3] !== 6'd60 || got_q[0].psum[4] !== 6'd11) begin
        failures++;
        $display("FAIL fifteen_psum: got %h required lane k=(15(k+1))%%64", got_q[0].psum);
      end
    end
    test_order("fifteen");
  endtask

  task automatic test_backpressure();
    lanes_in_t d [3];
    logic      l [3];
    int        n, guard;
    logic      acc;
    for (int i = 0; i < 3; i++) begin d[i] = rand_lanes(); l[i] = (i == 2); end
    bus.out_ready = 1'b0;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d[0]; bus.in_last = l[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      tick(1);
      if (acc) begin
        n++;
        if (n < 3) begin bus.in_data = d[n]; bus.in_last = l[n]; end else bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL bp_accepted: got %0d required 2", n); end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_stall: in_ready=%0b out_valid=%0b required 0 1", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    guard = 0;
    while (n < 3 && guard < 50) begin
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      tick(1);
      guard++;
      if (acc) begin n++; bus.in_valid = 1'b0; end
    end
    tick(4);
    test_order("bp");
  endtask

  task automatic test_random();
    logic acc;
    pulse_clear();
    exp_q.delete(); got_q.delete();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      tick(1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 4) != 0);
        bus.in_data = rand_lanes();
        bus.in_last = ($urandom_range(0, 3) == 0);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(5);
    test_order("random");
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    send_beat(fill(1), 1'b0);
    send_beat(fill(1), 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_full: out_valid=%0b in_ready=%0b required 1 0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_async: out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
    end
    tick(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick(1);
    exp_q.delete(); got_q.delete();
    send_beat(fill(1), 1'b1);
    tick(3);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL midrst_count: got %0d beats required 1", got_q.size());
    end else if (got_q[0].psum[0] !== 6'd1 || got_q[0].beat !== 8'd0 || got_q[0].total !== 6'd32) begin
      failures++;
      $display("FAIL midrst_beat: psum0=%0d beat=%0d total=%0d required 1 0 32",
               got_q[0].psum[0], got_q[0].beat, got_q[0].total);
    end
    test_order("midrst");
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_ones();
    test_back_to_back();
    test_clear();
    test_fifteen();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
